// File: rtl/wb_eventlog.sv
// wb_eventlog: Wishbone-readable FIFO of 8-bit event codes for firmware debug and trigger tracing.
// Define WB_EVENTLOG_TIMESTAMP_EN to store an 8-bit capture timestamp with each entry (register 4).
module wb_eventlog #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  event_data,
   input  logic        event_valid,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   input  logic [15:0] wb_adr_i,
   input  logic [7:0]  wb_dat_i,
   output logic [7:0]  wb_dat_o,
   output logic        wb_ack_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
`ifdef WB_EVENTLOG_TIMESTAMP_EN
   localparam int EW = 16;
`else
   localparam int EW = 8;
`endif

   logic [EW-1:0]         mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic [7:2]            ctrl;
   logic [EW-1:0]         head, entry;
   logic [8:0]            cnt9;
   logic [7:0]            cnt_sat, rdata;
   logic [2:0]            reg_sel;
   logic                  access, rd, wr, empty, full, pop, push, clr, clr_ovf, ovf_set;
   logic                  unused_adr;
`ifdef WB_EVENTLOG_TIMESTAMP_EN
   logic [7:0]            ts_cnt, tstamp;
`endif

   assign unused_adr = ^wb_adr_i[15:3];
   assign reg_sel    = wb_adr_i[2:0];
   assign access     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
   assign rd         = access & ~wb_we_i;
   assign wr         = access & wb_we_i;
   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign cnt9       = 9'(count);
   assign cnt_sat    = cnt9[8] ? 8'hFF : cnt9[7:0];
   assign head       = mem[rptr];

   // Clear outranks a same-cycle push; a pop frees a slot so a push into a full FIFO still lands.
   assign pop     = rd & (reg_sel == 3'd2) & ~empty;
   assign clr     = wr & (reg_sel == 3'd3) & wb_dat_i[0];
   assign clr_ovf = wr & (reg_sel == 3'd3) & wb_dat_i[1];
   assign push    = event_valid & ctrl[2] & (~full | pop) & ~clr;
   assign ovf_set = event_valid & ctrl[2] & full & ~pop & ~clr;

`ifdef WB_EVENTLOG_TIMESTAMP_EN
   assign entry = {ts_cnt, event_data};
`else
   assign entry = event_data;
`endif

   always_comb begin
      rdata = 8'h00;
      case (reg_sel)
         3'd0:    rdata = {5'b0, overflow, full, empty};
         3'd1:    rdata = cnt_sat;
         3'd2:    rdata = empty ? 8'h00 : head[7:0];
         3'd3:    rdata = {ctrl, 2'b00};
`ifdef WB_EVENTLOG_TIMESTAMP_EN
         3'd4:    rdata = tstamp;
`endif
         default: rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 8'h00;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         ctrl     <= '0;
      end else begin
         wb_ack_o <= access;
         if (rd) wb_dat_o <= rdata;
         if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
         if (wr && reg_sel == 3'd3) ctrl <= wb_dat_i[7:2];
      end
   end

`ifdef WB_EVENTLOG_TIMESTAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt <= 8'h00;
         tstamp <= 8'h00;
      end else begin
         ts_cnt <= ts_cnt + 8'd1;
         if (pop) tstamp <= head[15:8];
      end
   end
`endif

endmodule

// File: tb/tb_wb_eventlog.sv
// tb_wb_eventlog: table vectors, corner sequences and random traffic against a queue model of the event log.
// Honors WB_EVENTLOG_TIMESTAMP_EN the same way the design does.
module tb_wb_eventlog;
   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;
`ifdef WB_EVENTLOG_TIMESTAMP_EN
   localparam bit TS = 1'b1;
`else
   localparam bit TS = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  event_data = 8'h00;
   logic        event_valid = 1'b0;
   logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
   logic [15:0] wb_adr_i = 16'h0;
   logic [7:0]  wb_dat_i = 8'h00;
   logic [7:0]  wb_dat_o;
   logic        wb_ack_o;

   int errors = 0, checks = 0;
   logic [31:0] cyc;

   always #5 clk = ~clk;

   wb_eventlog #(.DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst(rst), .event_data(event_data), .event_valid(event_valid),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
   );

   // Free-running cycle count since reset: the timestamp an event should carry.
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;

   // Reference model: a plain queue of {timestamp, code} plus flags.
   typedef struct packed {logic [7:0] ts; logic [7:0] d;} ent_t;
   ent_t       q[$];
   logic       m_ovf = 1'b0;
   logic [7:0] m_ctrl = 8'h00, m_dat = 8'h00, m_tst = 8'h00;

   task automatic model_reset();
      q.delete(); m_ovf = 0; m_ctrl = 0; m_dat = 0; m_tst = 0;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit ev, input logic [7:0] evd, input bit acc, input bit we,
                        input logic [2:0] a, input logic [7:0] wd, input logic [7:0] ts);
      bit full, pop, clr, clro, en;
      logic [7:0] rv;
      full = (q.size() == DEPTH);
      en   = m_ctrl[2];
      if (acc && !we) begin
         case (a)
            3'd0: rv = {5'b0, m_ovf, full, q.size() == 0};
            3'd1: rv = (q.size() > 255) ? 8'hFF : 8'(q.size());
            3'd2: rv = (q.size() > 0) ? q[0].d : 8'h00;
            3'd3: rv = m_ctrl;
            3'd4: rv = TS ? m_tst : 8'h00;
            default: rv = 8'h00;
         endcase
         m_dat = rv;
      end
      pop  = acc && !we && a == 3'd2 && q.size() > 0;
      clr  = acc && we && a == 3'd3 && wd[0];
      clro = acc && we && a == 3'd3 && wd[1];
      if (pop) begin
         m_tst = q[0].ts;
         void'(q.pop_front());
      end
      if (clr) q.delete();
      else if (ev && en && (!full || pop)) q.push_back({ts, evd});
      if (clro) m_ovf = 0;
      if (ev && en && full && !pop && !clr) m_ovf = 1;
      if (acc && we && a == 3'd3) m_ctrl = wd & 8'hFC;
   endtask

   // One clock: drive at #1 after an edge, step the model, check ack/data #1 after the next edge.
   task automatic step(input bit ev, input logic [7:0] evd, input bit acc, input bit we,
                       input logic [2:0] a, input logic [7:0] wd);
      event_valid = ev; event_data = evd;
      wb_stb_i = acc; wb_cyc_i = acc; wb_we_i = we;
      wb_adr_i = {13'($urandom), a}; wb_dat_i = wd;
      model(ev, evd, acc, we, a, wd, cyc[7:0]);
      @(posedge clk); #1;
      event_valid = 0; wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
      chk("ack", {7'b0, wb_ack_o}, {7'b0, acc});
      chk("dat_o", wb_dat_o, m_dat);
   endtask

   task automatic bus(input bit we, input logic [2:0] a, input logic [7:0] wd,
                      input bit ev, input logic [7:0] evd, output logic [7:0] rd);
      step(ev, evd, 1, we, a, wd);
      rd = wb_dat_o;
      step(0, 8'h00, 0, 0, 3'd0, 8'h00);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] v;
      bus(0, a, 8'h00, 0, 8'h00, v);
      chk(name, v, exp);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      logic [7:0] v;
      bus(1, a, d, 0, 8'h00, v);
   endtask

   task automatic ev1(input logic [7:0] d);
      step(1, d, 0, 0, 3'd0, 8'h00);
   endtask

   typedef struct {
      bit         is_ev;
      bit         we;
      logic [2:0] a;
      logic [7:0] d;
      bit         ev;
      logic [7:0] evd;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic void R(input logic [2:0] a, input logic [7:0] exp);
      tbl.push_back('{0, 0, a, 8'h00, 0, 8'h00, exp});
   endfunction
   function automatic void RE(input logic [2:0] a, input logic [7:0] evd, input logic [7:0] exp);
      tbl.push_back('{0, 0, a, 8'h00, 1, evd, exp});
   endfunction
   function automatic void W(input logic [2:0] a, input logic [7:0] d);
      tbl.push_back('{0, 1, a, d, 0, 8'h00, 8'h00});
   endfunction
   function automatic void E(input logic [7:0] d);
      tbl.push_back('{1, 0, 3'd0, 8'h00, 1, d, 8'h00});
   endfunction

   initial begin
      logic [7:0] v, t0;
      bit pacc, acc, we, ev;
      logic [2:0] a;
      logic [7:0] wd;
      bit hit;

      R(0, 8'h01); R(1, 8'h00); R(2, 8'h00);
      W(3, 8'h04); R(3, 8'h04);
      E(8'hA5); E(8'h3C); R(1, 8'h02); R(2, 8'hA5); R(2, 8'h3C); R(0, 8'h01);
      for (int i = 1; i <= 5; i++) E(8'(i));
      R(0, 8'h06); R(1, 8'h04);
      for (int i = 1; i <= 4; i++) R(2, 8'(i));
      R(0, 8'h05); W(3, 8'h06); R(0, 8'h01); R(3, 8'h04);
      E(8'h11); E(8'h22); E(8'h33); E(8'h44);
      RE(2, 8'h77, 8'h11); R(0, 8'h02); R(1, 8'h04);
      R(2, 8'h22); R(2, 8'h33); R(2, 8'h44); R(2, 8'h77); R(0, 8'h01);

      #3;
      chk("rst_ack", {7'b0, wb_ack_o}, 8'h00);
      chk("rst_dat", wb_dat_o, 8'h00);
      @(posedge clk); #1; rst = 0;

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].is_ev) ev1(tbl[i].evd);
         else begin
            bus(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].ev, tbl[i].evd, v);
            if (!tbl[i].we) chk($sformatf("vec%0d_r%0d", i, tbl[i].a), v, tbl[i].exp);
         end
      end

      // Capture disabled: events vanish without raising overflow.
      wr(3, 8'h00);
      for (int i = 0; i < 10; i++) ev1(8'(8'hC0 + i));
      rd_chk("dis_count", 1, 8'h00);
      rd_chk("dis_status", 0, 8'h01);

      // Clear coincident with a push into a full FIFO: clear wins, overflow untouched.
      wr(3, 8'h04);
      for (int i = 0; i < 4; i++) ev1(8'(8'h50 + i));
      bus(1, 3, 8'h05, 1, 8'h99, v);
      rd_chk("clr_push_count", 1, 8'h00);
      rd_chk("clr_push_status", 0, 8'h01);

      // Pop on empty with a same-cycle push.
      bus(0, 2, 8'h00, 1, 8'h5A, v);
      chk("empty_pop_push", v, 8'h00);
      rd_chk("empty_pop_count", 1, 8'h01);
      rd_chk("empty_pop_data", 2, 8'h5A);

      // Held strobe: acks every second cycle.
      wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 0; wb_adr_i = 16'h0001;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) model(0, 8'h00, 1, 0, 3'd1, 8'h00, cyc[7:0]);
         @(posedge clk); #1;
         if (i == 3) begin wb_stb_i = 0; wb_cyc_i = 0; end
         chk("b2b_ack", {7'b0, wb_ack_o}, (i % 2 == 0) ? 8'h01 : 8'h00);
         chk("b2b_dat", wb_dat_o, m_dat);
      end
      step(0, 8'h00, 0, 0, 3'd0, 8'h00);

`ifdef WB_EVENTLOG_TIMESTAMP_EN
      wr(3, 8'h05);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 3'd0, 8'h00);
      t0 = cyc[7:0];
      ev1(8'hE1);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0, 3'd0, 8'h00);
      ev1(8'hE2);
      rd_chk("ts_pop1", 2, 8'hE1); rd_chk("ts_T", 4, t0);
      rd_chk("ts_pop2", 2, 8'hE2); rd_chk("ts_T7", 4, t0 + 8'd7);
      hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
         if (cyc[7:0] == 8'hFE) hit = 1;
         else step(0, 8'h00, 0, 0, 3'd0, 8'h00);
      end
      chk("ts_wrap_reached", {7'b0, hit}, 8'h01);
      ev1(8'hF1);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 0, 3'd0, 8'h00);
      ev1(8'hF2);
      rd_chk("ts_wrap_pop1", 2, 8'hF1); rd_chk("ts_FE", 4, 8'hFE);
      rd_chk("ts_wrap_pop2", 2, 8'hF2); rd_chk("ts_05", 4, 8'h05);
`else
      rd_chk("reg4_zero", 4, 8'h00);
`endif

      // Random traffic against the model.
      wr(3, 8'h04);
      pacc = 0;
      for (int i = 0; i < 600; i++) begin
         acc = !pacc && ($urandom_range(0, 1) == 1);
         we  = ($urandom_range(0, 3) == 0);
         a   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         wd  = (8'($urandom) & 8'hFC) | 8'h04;
         if ($urandom_range(0, 7) == 0) wd[0] = 1'b1;
         if ($urandom_range(0, 5) == 0) wd[1] = 1'b1;
         if ($urandom_range(0, 9) == 0) wd[2] = 1'b0;
         ev  = ($urandom_range(0, 2) != 0);
         step(ev, 8'($urandom), acc, we, a, wd);
         pacc = acc;
      end
      step(0, 8'h00, 0, 0, 3'd0, 8'h00);

      // Reset in the middle of an acked transaction drops ack at once.
      wb_stb_i = 1; wb_cyc_i = 1; wb_we_i = 0; wb_adr_i = 16'h0000;
      @(posedge clk); #1;
      chk("pre_rst_ack", {7'b0, wb_ack_o}, 8'h01);
      rst = 1; #1;
      chk("mid_rst_ack", {7'b0, wb_ack_o}, 8'h00);
      chk("mid_rst_dat", wb_dat_o, 8'h00);
      model_reset();
      @(posedge clk); #1;
      wb_stb_i = 0; wb_cyc_i = 0; rst = 0;
      rd_chk("post_rst_status", 0, 8'h01);
      rd_chk("post_rst_ctrl", 3, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
